// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_controller
// Description : Control unit for a five-stage ARM pipeline. Decodes the
//               instruction in Decode, carries control through the E/M/W
//               pipeline registers, owns the NZCV flags and evaluates the
//               condition code in Execute.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_ORR = 3'b011;

    // Decode-stage fields and controls
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [1:0] w_regsrc;
    logic [1:0] w_immsrc;
    logic       w_alusrc;
    logic       w_memtoreg;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic [2:0] w_aluctl;
    logic [1:0] w_flagw;
    logic       w_pcsrcd;
    logic       w_unused_bits;

    // Execute-stage registers
    logic       r_pcsrc_e;
    logic       r_regw_e;
    logic       r_memw_e;
    logic       r_memtoreg_e;
    logic       r_branch_e;
    logic [2:0] r_aluctl_e;
    logic       r_alusrc_e;
    logic [1:0] r_flagw_e;
    logic [3:0] r_cond_e;
    logic [3:0] r_flags;
    logic       w_condex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_pcsrc_e_g;

    // Memory / Writeback registers
    logic       r_pcsrc_m;
    logic       r_regw_m;
    logic       r_memw_m;
    logic       r_memtoreg_m;
    logic       r_pcsrc_w;
    logic       r_regw_w;
    logic       r_memtoreg_w;

    assign w_op          = InstrD[27:26];
    assign w_funct       = InstrD[25:20];
    assign w_cmd         = w_funct[4:1];
    assign w_s           = w_funct[0];
    assign w_unused_bits = ^InstrD[11:0];

    // Main decode and ALU decode; undefined DP commands become architectural no-ops
    always_comb begin
        w_regsrc   = 2'b00;
        w_immsrc   = 2'b00;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regw     = 1'b0;
        w_memw     = 1'b0;
        w_branch   = 1'b0;
        w_aluctl   = c_ALU_ADD;
        w_flagw    = 2'b00;
        case (w_op)
            2'b00: begin
                w_alusrc = w_funct[5];
                w_regw   = 1'b1;
                case (w_cmd)
                    4'b0100: begin w_aluctl = c_ALU_ADD; w_flagw = {w_s, w_s};  end
                    4'b0010: begin w_aluctl = c_ALU_SUB; w_flagw = {w_s, w_s};  end
                    4'b0000: begin w_aluctl = c_ALU_AND; w_flagw = {w_s, 1'b0}; end
                    4'b1100: begin w_aluctl = c_ALU_ORR; w_flagw = {w_s, 1'b0}; end
                    4'b1010: begin
                        w_aluctl = c_ALU_SUB;
                        w_flagw  = {w_s, w_s};
                        w_regw   = 1'b0;
                    end
                    default: begin
                        w_regw  = 1'b0;
                        w_flagw = 2'b00;
                    end
                endcase
            end
            2'b01: begin
                w_regsrc   = w_funct[0] ? 2'b00 : 2'b10;
                w_immsrc   = 2'b01;
                w_alusrc   = 1'b1;
                w_memtoreg = w_funct[0];
                w_regw     = w_funct[0];
                w_memw     = ~w_funct[0];
            end
            2'b10: begin
                w_regsrc = 2'b01;
                w_immsrc = 2'b10;
                w_alusrc = 1'b1;
                w_branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_pcsrcd = (InstrD[15:12] == 4'hF) & w_regw;

    // D->E control register; reset beats flush, flush inserts a bubble
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_pcsrc_e    <= 1'b0;
            r_regw_e     <= 1'b0;
            r_memw_e     <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_branch_e   <= 1'b0;
            r_aluctl_e   <= 3'b000;
            r_alusrc_e   <= 1'b0;
            r_flagw_e    <= 2'b00;
            r_cond_e     <= 4'h0;
        end else begin
            r_pcsrc_e    <= w_pcsrcd;
            r_regw_e     <= w_regw;
            r_memw_e     <= w_memw;
            r_memtoreg_e <= w_memtoreg;
            r_branch_e   <= w_branch;
            r_aluctl_e   <= w_aluctl;
            r_alusrc_e   <= w_alusrc;
            r_flagw_e    <= w_flagw;
            r_cond_e     <= InstrD[31:28];
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition evaluation from the architectural flags only (no ALUFlags path)
    always_comb begin
        w_condex = 1'b0;
        case (r_cond_e)
            4'h0: w_condex = w_z;
            4'h1: w_condex = ~w_z;
            4'h2: w_condex = w_c;
            4'h3: w_condex = ~w_c;
            4'h4: w_condex = w_n;
            4'h5: w_condex = ~w_n;
            4'h6: w_condex = w_v;
            4'h7: w_condex = ~w_v;
            4'h8: w_condex = w_c & ~w_z;
            4'h9: w_condex = ~w_c | w_z;
            4'hA: w_condex = (w_n == w_v);
            4'hB: w_condex = (w_n != w_v);
            4'hC: w_condex = ~w_z & (w_n == w_v);
            4'hD: w_condex = w_z | (w_n != w_v);
            4'hE: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // NZCV register; the two halves load independently when the instruction executes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'h0;
        end else begin
            if (r_flagw_e[1] && w_condex) r_flags[3:2] <= ALUFlags[3:2];
            if (r_flagw_e[0] && w_condex) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign w_pcsrc_e_g = r_pcsrc_e & w_condex;

    // E->M register; side-effecting controls are gated by the condition result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcsrc_m    <= 1'b0;
            r_regw_m     <= 1'b0;
            r_memw_m     <= 1'b0;
            r_memtoreg_m <= 1'b0;
        end else begin
            r_pcsrc_m    <= w_pcsrc_e_g;
            r_regw_m     <= r_regw_e & w_condex;
            r_memw_m     <= r_memw_e & w_condex;
            r_memtoreg_m <= r_memtoreg_e;
        end
    end

    // M->W register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcsrc_w    <= 1'b0;
            r_regw_w     <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else begin
            r_pcsrc_w    <= r_pcsrc_m;
            r_regw_w     <= r_regw_m;
            r_memtoreg_w <= r_memtoreg_m;
        end
    end

    assign RegSrcD      = w_regsrc;
    assign ImmSrcD      = w_immsrc;
    assign ALUSrcE      = r_alusrc_e;
    assign ALUControlE  = r_aluctl_e;
    assign BranchTakenE = r_branch_e & w_condex;
    assign MemtoRegE    = r_memtoreg_e;
    assign RegWriteM    = r_regw_m;
    assign MemWriteM    = r_memw_m;
    assign RegWriteW    = r_regw_w;
    assign MemtoRegW    = r_memtoreg_w;
    assign PCSrcW       = r_pcsrc_w;
    assign PCWrPendingF = w_pcsrcd | w_pcsrc_e_g | r_pcsrc_m;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_controller
// Description : Scoreboard bench for pipeline_controller. Each issued
//               instruction queues its expected E/M/W controls, which are
//               compared when the instruction reaches that stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic        BranchTakenE;
    logic        MemtoRegE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        PCSrcW;
    logic        PCWrPendingF;

    localparam logic [31:0] NOP   = 32'hEC000000;
    localparam logic [31:0] ADD   = 32'hE0801002;
    localparam logic [31:0] ADD15 = 32'hE080F002;
    localparam logic [31:0] ADDNE = 32'h10801002;
    localparam logic [31:0] SUBS  = 32'hE0521003;
    localparam logic [31:0] BEQ   = 32'h0A000002;
    localparam logic [31:0] BNE   = 32'h1A000002;
    localparam logic [31:0] BMI   = 32'h4A000002;
    localparam logic [31:0] BPL   = 32'h5A000002;
    localparam logic [31:0] LDR   = 32'hE5901004;
    localparam logic [31:0] STR   = 32'hE5801004;

    typedef struct {
        int         due;
        int         id;
        logic [2:0] exp;
    } sb_t;

    sb_t sb[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrD       (InstrD),
        .ALUFlags     (ALUFlags),
        .FlushE       (FlushE),
        .RegSrcD      (RegSrcD),
        .ImmSrcD      (ImmSrcD),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .BranchTakenE (BranchTakenE),
        .MemtoRegE    (MemtoRegE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF)
    );

    function automatic logic [2:0] get_sig(input int id);
        case (id)
            0: return {2'b00, ALUSrcE};
            1: return ALUControlE;
            2: return {2'b00, BranchTakenE};
            3: return {2'b00, MemtoRegE};
            4: return {2'b00, RegWriteM};
            5: return {2'b00, MemWriteM};
            6: return {2'b00, RegWriteW};
            7: return {2'b00, MemtoRegW};
            default: return {2'b00, PCSrcW};
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            0: return "ALUSrcE";
            1: return "ALUControlE";
            2: return "BranchTakenE";
            3: return "MemtoRegE";
            4: return "RegWriteM";
            5: return "MemWriteM";
            6: return "RegWriteW";
            7: return "MemtoRegW";
            default: return "PCSrcW";
        endcase
    endfunction

    function automatic void push(input int off, input int id, input logic [2:0] v);
        sb.push_back('{due: cyc + off, id: id, exp: v});
    endfunction

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                n_checks++;
                if (sb[i].due < cyc) begin
                    n_fail++;
                    $display("FAIL sb_overdue %s: due cycle %0d, now %0d", sig_name(sb[i].id), sb[i].due, cyc);
                end else if (get_sig(sb[i].id) !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got %0d expected %0d", sig_name(sb[i].id), cyc, get_sig(sb[i].id), sb[i].exp);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        FlushE = 1'b0;
        check_due();
    endtask

    // Put an instruction in Decode and queue its expected downstream controls
    task automatic issue(input logic [31:0] instr, input logic flush,
                         input logic [2:0] aluctl, input logic alusrc, input logic br,
                         input logic m2r, input logic rw, input logic mw, input logic pcs);
        InstrD = instr;
        FlushE = flush;
        push(1, 0, {2'b00, alusrc});
        push(1, 1, aluctl);
        push(1, 2, {2'b00, br});
        push(1, 3, {2'b00, m2r});
        push(2, 4, {2'b00, rw});
        push(2, 5, {2'b00, mw});
        push(3, 6, {2'b00, rw});
        push(3, 7, {2'b00, m2r});
        push(3, 8, {2'b00, pcs});
        #1;
    endtask

    task automatic nop();
        issue(NOP, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        InstrD = NOP;
        FlushE = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        InstrD   = 32'h0;
        FlushE   = 1'b0;
        ALUFlags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int id = 0; id < 9; id++) begin
            n_checks++;
            if (get_sig(id) !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_%s: got %0d expected 0", sig_name(id), get_sig(id));
            end
        end
        n_checks++;
        if (PCWrPendingF !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_PCWrPendingF: got %b expected 0", PCWrPendingF);
        end
        InstrD = NOP;
        tick();
        // Flags cleared to 0000: NE taken, MI not taken, PL taken
        issue(BNE, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        issue(BMI, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        issue(BPL, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drain();
    endtask

    task automatic test_add();
        issue(ADD, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (RegSrcD !== 2'b00 || ImmSrcD !== 2'b00) begin
            n_fail++;
            $display("FAIL add_decode: RegSrcD=%b ImmSrcD=%b expected 00 00", RegSrcD, ImmSrcD);
        end
        n_checks++;
        if (PCWrPendingF !== 1'b0) begin
            n_fail++;
            $display("FAIL add_pcwr: got %b expected 0", PCWrPendingF);
        end
        tick();
        nop();
        tick();
        drain();
    endtask

    task automatic test_subs_beq();
        // Z set by SUBS: BEQ taken
        issue(SUBS, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b0100;
        issue(BEQ, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (RegSrcD !== 2'b01 || ImmSrcD !== 2'b10) begin
            n_fail++;
            $display("FAIL beq_decode: RegSrcD=%b ImmSrcD=%b expected 01 10", RegSrcD, ImmSrcD);
        end
        tick();
        ALUFlags = 4'b0000;
        nop();
        tick();
        drain();
        // Z cleared by SUBS: BEQ not taken even with Z on the live ALU flags
        issue(SUBS, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b0000;
        issue(BEQ, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b0100;
        nop();
        tick();
        ALUFlags = 4'b0000;
        drain();
    endtask

    task automatic test_ldr_str();
        issue(LDR, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ImmSrcD !== 2'b01 || RegSrcD !== 2'b00) begin
            n_fail++;
            $display("FAIL ldr_decode: RegSrcD=%b ImmSrcD=%b expected 00 01", RegSrcD, ImmSrcD);
        end
        tick();
        issue(STR, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (RegSrcD !== 2'b10 || ImmSrcD !== 2'b01) begin
            n_fail++;
            $display("FAIL str_decode: RegSrcD=%b ImmSrcD=%b expected 10 01", RegSrcD, ImmSrcD);
        end
        tick();
        drain();
    endtask

    task automatic test_flush();
        issue(ADD, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        issue(ADD, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drain();
    endtask

    task automatic test_pc_write();
        issue(ADD15, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (PCWrPendingF !== (k < 3)) begin
                n_fail++;
                $display("FAIL pcwr_pending_%0d: got %b expected %b", k, PCWrPendingF, (k < 3));
            end
            tick();
            nop();
        end
        tick();
        drain();
    endtask

    task automatic test_cond_not_taken();
        issue(SUBS, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b0100;
        issue(ADDNE, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b0000;
        issue(BEQ, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        issue(BNE, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        InstrD = SUBS;
        @(posedge clk);
        #1;
        ALUFlags = 4'b0100;
        InstrD   = ADD;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        InstrD   = NOP;
        ALUFlags = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (RegWriteM !== 1'b0 || RegWriteW !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_regwrite: M=%b W=%b expected 0 0", RegWriteM, RegWriteW);
        end
        issue(BEQ, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_subs_beq();
        test_ldr_str();
        test_flush();
        test_pc_write();
        test_cond_not_taken();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
